mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/cpu_types_pkg.sv | 25 ++
 rtl/mem_arbiter_if.sv | 40 ++++
 rtl/mem_arbiter.sv | 112 +++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types.
//   word_t      : machine word (address and data)
//   ramstate_t  : status reported by the RAM each cycle
//   arb_state_t : states of the instruction/data memory arbiter
package cpu_types_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE,
    BUSY,
    ACCESS,
    ERROR
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE,
    IGRANT,
    DGRANT,
    RELEASE
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus between the CPU fetch/data ports, the arbiter and the RAM.
//   slave  : arbiter view (takes requests and RAM status, drives waits, loads, RAM controls)
//   master : CPU/RAM side view (drives requests and RAM status, observes the rest)
interface mem_arbiter_if import cpu_types_pkg::*; #(
  parameter int unsigned ADDR_W = WORD_W
);

  // Instruction port
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic              iwait;
  logic [ADDR_W-1:0] iload;

  // Data port
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [ADDR_W-1:0] dstore;
  logic              dwait;
  logic [ADDR_W-1:0] dload;

  // RAM port
  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [ADDR_W-1:0] ramstore;
  logic [ADDR_W-1:0] ramload;
  ramstate_t         ramstate;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates a single RAM port between instruction fetches and data accesses.
// Data normally wins; an instruction fetch that has watched STARVE_LIMIT consecutive
// data grants is granted next regardless. Each completed access is followed by one
// RELEASE cycle so requesters can drop or change their request.
// Ports:
//   CLK  : clock, rising edge
//   nRST : asynchronous active-low reset
//   bus  : mem_arbiter_if.slave (instruction, data and RAM signals)
// STARVE_LIMIT must be at least 1.
module mem_arbiter import cpu_types_pkg::*; #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned ADDR_W       = WORD_W
) (
  input  logic         CLK,
  input  logic         nRST,
  mem_arbiter_if.slave bus
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_LIMIT);

  arb_state_t      state_q, state_d;
  logic [CntW-1:0] starve_q, starve_d;

  logic              dreq;
  logic              iresp;
  logic              dresp;
  logic              ram_ren;
  logic              ram_wen;
  logic [ADDR_W-1:0] ram_addr;
  logic [ADDR_W-1:0] ram_store;

  assign dreq = bus.dREN | bus.dWEN;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    iresp     = 1'b0;
    dresp     = 1'b0;
    ram_ren   = 1'b0;
    ram_wen   = 1'b0;
    ram_addr  = '0;
    ram_store = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.iREN && (starve_q == StarveMax)) begin
          state_d = IGRANT;
        end else if (dreq) begin
          state_d = DGRANT;
        end else if (bus.iREN) begin
          state_d = IGRANT;
        end
      end
      IGRANT: begin
        ram_ren  = 1'b1;
        ram_addr = bus.iaddr;
        if (!bus.iREN) begin
          state_d = IDLE;
        end else if (bus.ramstate == ACCESS) begin
          iresp   = 1'b1;
          state_d = RELEASE;
        end
      end
      DGRANT: begin
        ram_addr  = bus.daddr;
        ram_store = bus.dstore;
        // Write takes priority when both enables are set.
        ram_wen   = bus.dWEN;
        ram_ren   = ~bus.dWEN;
        if (!dreq) begin
          state_d = IDLE;
        end else if (bus.ramstate == ACCESS) begin
          dresp   = 1'b1;
          state_d = RELEASE;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counts data grants taken while a fetch is waiting; saturates so the fetch wins next.
  always_comb begin
    starve_d = starve_q;
    if (!bus.iREN) begin
      starve_d = '0;
    end else if (state_q == IDLE && state_d == IGRANT) begin
      starve_d = '0;
    end else if (state_q == IDLE && state_d == DGRANT && starve_q != StarveMax) begin
      starve_d = starve_q + 1'b1;
    end
  end

  assign bus.ramREN   = ram_ren;
  assign bus.ramWEN   = ram_wen;
  assign bus.ramaddr  = ram_addr;
  assign bus.ramstore = ram_store;
  assign bus.iwait    = bus.iREN & ~iresp;
  assign bus.dwait    = dreq & ~dresp;
  assign bus.iload    = iresp ? bus.ramload : '0;
  assign bus.dload    = dresp ? bus.ramload : '0;

endmodule
